// File: rtl/wb_timer_pkg.sv
// wb_timer shared definitions
// register offsets, field indices and byte-lane helper
package wb_timer_pkg;

  typedef logic [63:0] timer_t;

  localparam logic [2:0] MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMECMP_HI = 3'd3;
  localparam logic [2:0] CTRL        = 3'd4;
  localparam logic [2:0] PRESCALE    = 3'd5;

  localparam int NUM_REGS = 6;
  localparam int CTRL_EN  = 0;

  function automatic logic [31:0] merge_be(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone pipelined bus bundle
// master drives request, slave drives response
interface wb_if (
  input logic clk,
  input logic rst
);

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    input  clk, rst, ack, err, stall, dat_s,
    output cyc, stb, we, adr, sel, dat_m
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, sel, dat_m,
    output ack, err, stall, dat_s
  );

endinterface

// File: rtl/wb_timer_prescaler.sv
// mtime prescaler: down-counter, one tick per
// PRESCALE+1 enabled cycles
module wb_timer_prescaler #(
  parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] prescale,
  input  logic        reload,
  output logic        tick
);

  logic [15:0] pcnt;

  assign tick = en && (pcnt == 16'd0);

  // reload wins; otherwise count down while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= PRESCALE_RESET;
    end else if (reload || tick) begin
      pcnt <= prescale;
    end else if (en) begin
      pcnt <= pcnt - 16'd1;
    end
  end

endmodule

// File: rtl/wb_timer.sv
// RISC-V machine timer on a Wishbone slave port
// never stalls, responds one cycle after each request
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter timer_t      MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
  input  logic clk,
  input  logic rst_n,
  wb_if.slave  wb,
  output logic irq_timer_o
);

  timer_t      mtime;
  timer_t      mtimecmp;
  logic        en;
  logic [15:0] prescale;

  logic        req;
  logic [2:0]  idx;
  logic [NUM_REGS-1:0] hit;
  logic [NUM_REGS-1:0] wr_hit;
  logic        miss;

  logic [31:0] lo_new;
  logic [31:0] hi_new;
  logic [31:0] cmp_lo_new;
  logic [31:0] cmp_hi_new;
  logic [31:0] pre_wd;
  logic [15:0] prescale_nxt;
  logic        en_nxt;
  logic        reload;
  logic        tick;
  logic [31:0] rdata;

  logic        ack_q;
  logic        err_q;
  logic [31:0] dat_q;

  logic unused_bits;

  assign req = wb.cyc & wb.stb;
  assign idx = wb.adr[4:2];

  // one-hot register select; 0x18/0x1C select nothing
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = req && (idx == 3'(i));
    end
  end

  assign miss   = req && (hit == '0);
  assign wr_hit = hit & {NUM_REGS{wb.we}};

  // byte-lane merged next values for each write target
  always_comb begin
    lo_new     = mtime[31:0];
    hi_new     = mtime[63:32];
    cmp_lo_new = mtimecmp[31:0];
    cmp_hi_new = mtimecmp[63:32];
    pre_wd     = merge_be({16'h0, prescale}, wb.dat_m, wb.sel);
    if (wr_hit[MTIME_LO])
      lo_new = merge_be(mtime[31:0], wb.dat_m, wb.sel);
    if (wr_hit[MTIME_HI])
      hi_new = merge_be(mtime[63:32], wb.dat_m, wb.sel);
    if (wr_hit[MTIMECMP_LO])
      cmp_lo_new = merge_be(mtimecmp[31:0], wb.dat_m, wb.sel);
    if (wr_hit[MTIMECMP_HI])
      cmp_hi_new = merge_be(mtimecmp[63:32], wb.dat_m, wb.sel);
  end

  assign prescale_nxt = wr_hit[PRESCALE] ? pre_wd[15:0] : prescale;
  assign en_nxt = (wr_hit[CTRL] && wb.sel[0]) ? wb.dat_m[CTRL_EN] : en;
  assign reload = wr_hit[CTRL] | wr_hit[PRESCALE];

  wb_timer_prescaler #(
    .PRESCALE_RESET(PRESCALE_RESET)
  ) u_presc (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .prescale(prescale_nxt),
    .reload  (reload),
    .tick    (tick)
  );

  // read mux on pre-update register values
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit[MTIME_LO]:    rdata = mtime[31:0];
      hit[MTIME_HI]:    rdata = mtime[63:32];
      hit[MTIMECMP_LO]: rdata = mtimecmp[31:0];
      hit[MTIMECMP_HI]: rdata = mtimecmp[63:32];
      hit[CTRL]:        rdata = {31'h0, en};
      hit[PRESCALE]:    rdata = {16'h0, prescale};
      default:          rdata = '0;
    endcase
  end

  // register file; a bus write to mtime discards that cycle's tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RESET;
      en       <= 1'b0;
      prescale <= PRESCALE_RESET;
    end else begin
      if (wr_hit[MTIME_LO] || wr_hit[MTIME_HI])
        mtime <= {hi_new, lo_new};
      else if (tick)
        mtime <= mtime + 64'd1;
      mtimecmp <= {cmp_hi_new, cmp_lo_new};
      en       <= en_nxt;
      prescale <= prescale_nxt;
    end
  end

  // single-cycle bus response and registered interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dat_q       <= '0;
      irq_timer_o <= 1'b0;
    end else begin
      ack_q       <= req && !miss;
      err_q       <= miss;
      dat_q       <= (req && !wb.we && !miss) ? rdata : '0;
      irq_timer_o <= (mtime >= mtimecmp);
    end
  end

  assign wb.ack   = ack_q;
  assign wb.err   = err_q;
  assign wb.dat_s = dat_q;
  assign wb.stall = 1'b0;

  assign unused_bits = ^{wb.adr[31:5], wb.adr[1:0],
                         pre_wd[31:16], wb.clk, wb.rst};

endmodule
